// File: rtl/hsi_s_tx_arb.sv
// ============================================================================
// Module   : hsi_s_tx_arb
// Brief    : Round-robin packet arbiter feeding the HSI slave tx byte path,
//            with a per-state watchdog that aborts stalled packets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hsi_s_tx_arb #(
  parameter int TO_CYC = 1024,
  parameter int TO_W   = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] src_req,
  input  logic [7:0] src0_d,
  input  logic [7:0] src1_d,
  input  logic [1:0] src_vld,
  input  logic [1:0] src_last,
  output logic [1:0] src_ack,
  output logic [1:0] src_gnt,
  output logic       sd_busy,
  output logic       sd_d_tx_rdy,
  input  logic       sd_d_tx_en,
  output logic [7:0] sd_d,
  output logic       sd_d_rdy,
  input  logic       sd_d_sending,
  output logic       sd_has_next_dp,
  output logic       pkt_done,
  output logic       pkt_abort
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OFFER  = 3'd1,
    S_LOAD   = 3'd2,
    S_PUSH   = 3'd3,
    S_WAIT_S = 3'd4,
    S_WAIT_E = 3'd5,
    S_DONE   = 3'd6,
    S_ABORT  = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] WD_LIM = TO_W'(TO_CYC - 1);

  state_t          state;
  logic [TO_W-1:0] wdog;
  logic            gidx;    // index of the granted source
  logic            rr;      // index of the source granted last
  logic            last_r;

  logic            sel_vld;
  logic            sel_last;
  logic [7:0]      sel_d;
  logic [1:0]      gnt_oh;
  logic            new_idx;
  logic            wd_active;
  logic            timeout;

  assign sel_vld   = gidx ? src_vld[1]  : src_vld[0];
  assign sel_last  = gidx ? src_last[1] : src_last[0];
  assign sel_d     = gidx ? src1_d      : src0_d;
  assign gnt_oh    = gidx ? 2'b10       : 2'b01;
  // Both requesting: the source not served last wins.
  assign new_idx   = (&src_req) ? ~rr : src_req[1];
  assign wd_active = (state == S_OFFER) || (state == S_LOAD) || (state == S_WAIT_S);
  assign timeout   = wd_active && (wdog == WD_LIM);

  // Ack marks the byte consumed in the same cycle it is latched.
  assign src_ack   = ((state == S_LOAD) && sel_vld) ? gnt_oh : 2'b00;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= S_IDLE;
      wdog           <= '0;
      gidx           <= 1'b0;
      rr             <= 1'b1;
      last_r         <= 1'b0;
      src_gnt        <= 2'b00;
      sd_busy        <= 1'b0;
      sd_d_tx_rdy    <= 1'b0;
      sd_d           <= 8'h00;
      sd_d_rdy       <= 1'b0;
      sd_has_next_dp <= 1'b0;
      pkt_done       <= 1'b0;
      pkt_abort      <= 1'b0;
    end else begin
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      sd_d_rdy  <= 1'b0;
      wdog      <= wd_active ? wdog + 1'b1 : '0;

      case (state)
        S_IDLE: begin
          if (|src_req) begin
            state       <= S_OFFER;
            gidx        <= new_idx;
            src_gnt     <= new_idx ? 2'b10 : 2'b01;
            sd_busy     <= 1'b1;
            sd_d_tx_rdy <= 1'b1;
            wdog        <= '0;
          end
        end
        S_OFFER: begin
          if (sd_d_tx_en) begin
            state       <= S_LOAD;
            sd_d_tx_rdy <= 1'b0;
            wdog        <= '0;
          end else if (timeout) begin
            state       <= S_ABORT;
            sd_d_tx_rdy <= 1'b0;
            src_gnt     <= 2'b00;
            pkt_abort   <= 1'b1;
            wdog        <= '0;
          end
        end
        S_LOAD: begin
          if (sel_vld) begin
            state          <= S_PUSH;
            sd_d           <= sel_d;
            last_r         <= sel_last;
            sd_has_next_dp <= ~sel_last;
            sd_d_rdy       <= 1'b1;
            wdog           <= '0;
          end else if (timeout) begin
            state     <= S_ABORT;
            src_gnt   <= 2'b00;
            pkt_abort <= 1'b1;
            wdog      <= '0;
          end
        end
        S_PUSH: begin
          state <= S_WAIT_S;
          wdog  <= '0;
        end
        S_WAIT_S: begin
          if (sd_d_sending) begin
            state <= S_WAIT_E;
            wdog  <= '0;
          end else if (timeout) begin
            state     <= S_ABORT;
            src_gnt   <= 2'b00;
            pkt_abort <= 1'b1;
            wdog      <= '0;
          end
        end
        S_WAIT_E: begin
          if (!sd_d_sending) begin
            wdog <= '0;
            if (last_r) begin
              state    <= S_DONE;
              src_gnt  <= 2'b00;
              pkt_done <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_DONE, S_ABORT: begin
          state   <= S_IDLE;
          rr      <= gidx;
          sd_busy <= 1'b0;
          wdog    <= '0;
        end
        default: begin
          state <= S_IDLE;
          wdog  <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
